// File: rtl/flag_int_unit.sv
// Flag and interrupt unit: architectural C/Z/I flags with shadow copies,
// plus the external interrupt synchroniser, edge detect and pending latch.
module flag_int_unit #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic alu_c,
  input  logic alu_z,
  input  logic flg_c_set,
  input  logic flg_c_clr,
  input  logic flg_c_ld,
  input  logic flg_z_ld,
  input  logic flg_ld_sel,
  input  logic flg_shad_ld,
  input  logic i_set,
  input  logic i_clr,
  input  logic int_ack,
  input  logic int_in,
  output logic c,
  output logic z,
  output logic i_en,
  output logic int_req
);

  logic                   r_c, r_z, r_i;
  logic                   r_shad_c, r_shad_z, r_shad_i;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_d;
  logic                   r_edge;
  logic                   r_pend;

  logic w_ld_c, w_ld_z, w_restore, w_rise;

  always_comb begin
    w_ld_c    = flg_ld_sel ? r_shad_c : alu_c;
    w_ld_z    = flg_ld_sel ? r_shad_z : alu_z;
    w_restore = flg_ld_sel & (flg_c_ld | flg_z_ld);
    w_rise    = r_sync[SYNC_STAGES-1] & ~r_sync_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_c      <= 1'b0;
      r_z      <= 1'b0;
      r_i      <= 1'b0;
      r_shad_c <= 1'b0;
      r_shad_z <= 1'b0;
      r_shad_i <= 1'b0;
      r_sync   <= '0;
      r_sync_d <= 1'b0;
      r_edge   <= 1'b0;
      r_pend   <= 1'b0;
    end else begin
      if (flg_c_clr)      r_c <= 1'b0;
      else if (flg_c_set) r_c <= 1'b1;
      else if (flg_c_ld)  r_c <= w_ld_c;

      if (flg_z_ld) r_z <= w_ld_z;

      if (int_ack || i_clr) r_i <= 1'b0;
      else if (i_set)       r_i <= 1'b1;
      else if (w_restore)   r_i <= r_shad_i;

      // Shadow captures pre-edge flags, so load+restore together is a swap.
      if (flg_shad_ld) begin
        r_shad_c <= r_c;
        r_shad_z <= r_z;
        r_shad_i <= r_i;
      end

      r_sync   <= {r_sync[SYNC_STAGES-2:0], int_in};
      r_sync_d <= r_sync[SYNC_STAGES-1];
      // Registered edge pulse sets int_pend SYNC_STAGES+1 edges after sampling;
      // a fresh edge outranks int_ack so that event is not lost.
      r_edge   <= w_rise;
      if (r_edge)       r_pend <= 1'b1;
      else if (int_ack) r_pend <= 1'b0;
    end
  end

  assign c       = r_c;
  assign z       = r_z;
  assign i_en    = r_i;
  assign int_req = r_pend & r_i;

endmodule

// File: tb/tb_flag_int_unit.sv
// Bench for flag_int_unit: fixed vector table, directed interrupt sequences,
// and randomized traffic against a sample-history reference model.
module tb_flag_int_unit;

  localparam int SS = 2;

  logic clk = 1'b0;
  logic reset, alu_c, alu_z, flg_c_set, flg_c_clr, flg_c_ld, flg_z_ld;
  logic flg_ld_sel, flg_shad_ld, i_set, i_clr, int_ack, int_in;
  logic c, z, i_en, int_req;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  flag_int_unit #(.SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .alu_c(alu_c), .alu_z(alu_z),
    .flg_c_set(flg_c_set), .flg_c_clr(flg_c_clr), .flg_c_ld(flg_c_ld),
    .flg_z_ld(flg_z_ld), .flg_ld_sel(flg_ld_sel), .flg_shad_ld(flg_shad_ld),
    .i_set(i_set), .i_clr(i_clr), .int_ack(int_ack), .int_in(int_in),
    .c(c), .z(z), .i_en(i_en), .int_req(int_req)
  );

  // Reference model: flags by priority rules; interrupt events found from the
  // history of int_in samples taken at each edge (index 0 = newest).
  bit m_c, m_z, m_i, m_sc, m_sz, m_si, m_pend;
  bit hist [SS+2];

  task automatic model_step();
    bit ev, rest, oc, oz, oi;
    if (reset) begin
      {m_c, m_z, m_i, m_sc, m_sz, m_si, m_pend} = '0;
      for (int j = 0; j < SS + 2; j++) hist[j] = 1'b0;
    end else begin
      oc = m_c; oz = m_z; oi = m_i;
      ev   = hist[SS] && !hist[SS+1];
      rest = flg_ld_sel && (flg_c_ld || flg_z_ld);
      if (flg_c_clr)      m_c = 1'b0;
      else if (flg_c_set) m_c = 1'b1;
      else if (flg_c_ld)  m_c = flg_ld_sel ? m_sc : alu_c;
      if (flg_z_ld)       m_z = flg_ld_sel ? m_sz : alu_z;
      if (int_ack)        m_i = 1'b0;
      else if (i_clr)     m_i = 1'b0;
      else if (i_set)     m_i = 1'b1;
      else if (rest)      m_i = m_si;
      if (flg_shad_ld) begin
        m_sc = oc; m_sz = oz; m_si = oi;
      end
      if (ev)           m_pend = 1'b1;
      else if (int_ack) m_pend = 1'b0;
      for (int j = SS + 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = int_in;
    end
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("model_c", c, m_c);
    check("model_z", z, m_z);
    check("model_i_en", i_en, m_i);
    check("model_int_req", int_req, m_pend & m_i);
  endtask

  task automatic clear_in();
    {reset, alu_c, alu_z, flg_c_set, flg_c_clr, flg_c_ld, flg_z_ld} = '0;
    {flg_ld_sel, flg_shad_ld, i_set, i_clr, int_ack} = '0;
  endtask

  typedef struct {
    bit rst, ac, az, cset, cclr, cld, zld, sel, shld, iset, iclr, ack;
    bit ec, ez, ei;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  initial begin
    clear_in();
    int_in = 1'b0;
    //            rst ac az cs cc cl zl sl sh is ic ak   c  z  i
    vecs[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0};
    vecs[1]  = '{0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0,  1, 1, 0};
    vecs[2]  = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0};
    vecs[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 0};
    vecs[4]  = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0,  1, 0, 1};
    vecs[5]  = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0,  0, 1, 0};
    vecs[6]  = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0,  1, 1, 1};
    vecs[7]  = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0,  1, 0, 1};
    vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0};
    vecs[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 1};
    vecs[10] = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0,  1, 0, 0};
    vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 1};
    vecs[12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 1};
    vecs[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1,  0, 0, 0};
    vecs[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0,  0, 0, 0};
    vecs[15] = '{0, 0, 1, 1, 0, 0, 1, 0, 0, 1, 0, 0,  1, 1, 1};
    vecs[16] = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0};
    vecs[17] = '{0, 0, 1, 1, 0, 0, 1, 0, 0, 1, 0, 0,  1, 1, 1};
    vecs[18] = '{0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0,  0, 0, 0};
    vecs[19] = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0,  0, 0, 1};
    vecs[20] = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 1};
    vecs[21] = '{0, 0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0,  0, 1, 1};
    vecs[22] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 1};

    for (int k = 0; k < NV; k++) begin
      reset = vecs[k].rst; alu_c = vecs[k].ac; alu_z = vecs[k].az;
      flg_c_set = vecs[k].cset; flg_c_clr = vecs[k].cclr;
      flg_c_ld = vecs[k].cld; flg_z_ld = vecs[k].zld;
      flg_ld_sel = vecs[k].sel; flg_shad_ld = vecs[k].shld;
      i_set = vecs[k].iset; i_clr = vecs[k].iclr; int_ack = vecs[k].ack;
      tick();
      check($sformatf("vec%0d_c", k), c, vecs[k].ec);
      check($sformatf("vec%0d_z", k), z, vecs[k].ez);
      check($sformatf("vec%0d_i_en", k), i_en, vecs[k].ei);
      check($sformatf("vec%0d_int_req", k), int_req, 1'b0);
    end
    clear_in();

    // Interrupt latency, ack, and held-high line.
    reset = 1'b1; tick(); reset = 1'b0;
    i_set = 1'b1; tick(); i_set = 1'b0;
    int_in = 1'b1;
    tick(); check("lat_e0", int_req, 1'b0);
    tick(); check("lat_e1", int_req, 1'b0);
    tick(); check("lat_e2", int_req, 1'b0);
    tick(); check("lat_e3", int_req, 1'b1);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    check("ack_req", int_req, 1'b0);
    check("ack_i_en", i_en, 1'b0);
    i_set = 1'b1; tick(); i_set = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick(); check("held_high_req", int_req, 1'b0);
    end

    // Masked pending.
    i_clr = 1'b1; tick(); i_clr = 1'b0;
    int_in = 1'b0; tick(); tick();
    int_in = 1'b1; tick(); tick();
    int_in = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick(); check("masked_req", int_req, 1'b0);
    end
    i_set = 1'b1; tick(); i_set = 1'b0;
    check("unmask_req", int_req, 1'b1);

    // Ack colliding with a fresh synchronised edge.
    for (int k = 0; k < 4; k++) tick();
    int_in = 1'b1;
    tick(); tick(); tick();
    check("pre_coll_req", int_req, 1'b1);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    check("coll_i_en", i_en, 1'b0);
    check("coll_req", int_req, 1'b0);
    i_set = 1'b1; tick(); i_set = 1'b0;
    check("coll_pend_kept", int_req, 1'b1);

    // Reset mid-operation with shadow loaded and pend set.
    flg_c_set = 1'b1; flg_z_ld = 1'b1; alu_z = 1'b1; tick(); clear_in();
    flg_shad_ld = 1'b1; tick(); flg_shad_ld = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    check("rst_c", c, 1'b0);
    check("rst_z", z, 1'b0);
    check("rst_i_en", i_en, 1'b0);
    check("rst_req", int_req, 1'b0);
    flg_c_set = 1'b1; flg_z_ld = 1'b1; alu_z = 1'b1; i_set = 1'b1; tick(); clear_in();
    check("rst_pend_gone", int_req, 1'b0);
    flg_ld_sel = 1'b1; flg_c_ld = 1'b1; flg_z_ld = 1'b1; tick(); clear_in();
    check("rst_shad_c", c, 1'b0);
    check("rst_shad_z", z, 1'b0);
    check("rst_shad_i", i_en, 1'b0);
    int_in = 1'b0;

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      reset       = ($urandom_range(0, 63) == 0);
      alu_c       = $urandom_range(0, 1);
      alu_z       = $urandom_range(0, 1);
      flg_c_set   = ($urandom_range(0, 4) == 0);
      flg_c_clr   = ($urandom_range(0, 4) == 0);
      flg_c_ld    = ($urandom_range(0, 3) == 0);
      flg_z_ld    = ($urandom_range(0, 3) == 0);
      flg_ld_sel  = $urandom_range(0, 1);
      flg_shad_ld = ($urandom_range(0, 4) == 0);
      i_set       = ($urandom_range(0, 5) == 0);
      i_clr       = ($urandom_range(0, 7) == 0);
      int_ack     = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 5) == 0) int_in = ~int_in;
      tick();
    end
    clear_in();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
